// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the display scan block.
// FSM state enum, widths, 7-segment table, BCD add-3 helper.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam int IN_W  = 12;
  localparam int DIG_N = 4;
  localparam int BCD_W = 16;

  // Active-high segments, bit 6 = a .. bit 0 = g.
  // Codes 10..15 are never produced by the converter; they stay dark.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_seg7_dec.sv
// seg7_dec: combinational BCD nibble to 7-segment pattern.
// Ports: nib (4-bit digit code), seg (7-bit active-high a..g).
module seg7_dec
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TAB[nib];

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 12-bit binary to 4-digit BCD, multiplexed 7-seg scan.
// Ports: CLK_i, RST_i (sync, active-high); IN_i/IN_VALID_i/IN_READY_o
// value handshake; CONV_DONE_o commit pulse; SEG_o (a..g), DIG_o
// (one-hot, bit 0 = units). Macro BLANK_LZ_EN enables leading-zero blanking.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic [IN_W-1:0]  IN_i,
  input  logic             IN_VALID_i,
  output logic             IN_READY_o,
  output logic             CONV_DONE_o,
  output logic [6:0]       SEG_o,
  output logic [DIG_N-1:0] DIG_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);

  state_t state, state_nx;

  logic [IN_W-1:0]  sh;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] disp;
  logic [3:0]       cnt;
  logic [PW-1:0]    presc;
  logic [1:0]       idx;
  logic             shift_en;
  logic             accept;
  logic             last_shift;
  logic [3:0]       nib;
  logic [6:0]       seg_raw;
  logic             blank;
  logic             unused_msb;

  assign accept     = IN_VALID_i & IN_READY_o;
  assign last_shift = (cnt == 4'd11);

  always_ff @(posedge CLK_i) begin
    if (RST_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (IN_VALID_i) state_nx = CONV;
      CONV:    if (last_shift) state_nx = LOAD;
      LOAD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    IN_READY_o  = 1'b0;
    CONV_DONE_o = 1'b0;
    shift_en    = 1'b0;
    unique case (1'b1)
      state == IDLE: IN_READY_o  = 1'b1;
      state == CONV: shift_en    = 1'b1;
      state == LOAD: CONV_DONE_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIG_N; i++)
      bcd_adj[4*i +: 4] = add3(bcd[4*i +: 4]);
  end

  // The top BCD bit never carries a value for 12-bit inputs (max 4095).
  assign unused_msb = bcd_adj[BCD_W-1];

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      disp <= '0;
    end else begin
      if (accept) begin
        sh  <= IN_i;
        bcd <= '0;
        cnt <= '0;
      end else if (shift_en) begin
        bcd <= {bcd_adj[BCD_W-2:0], sh[IN_W-1]};
        sh  <= {sh[IN_W-2:0], 1'b0};
        cnt <= cnt + 4'd1;
      end
      if (CONV_DONE_o) disp <= bcd;
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == P_LAST) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign nib = disp[{idx, 2'b00} +: 4];

  seg7_dec u_dec (
    .nib (nib),
    .seg (seg_raw)
  );

`ifdef BLANK_LZ_EN
  // A digit goes dark when it and every digit above it are zero.
  always_comb begin
    blank = 1'b0;
    unique case (idx)
      2'd1:    blank = ~|disp[15:4];
      2'd2:    blank = ~|disp[15:8];
      2'd3:    blank = ~|disp[15:12];
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  assign SEG_o = blank ? 7'b0000000 : seg_raw;
  assign DIG_o = 4'b0001 << idx;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: table vectors, directed corner sequences and
// random stimulus vs. an arithmetic reference model.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_val;
  logic        in_valid;
  logic        rdy1, done1, rdy4, done4;
  logic [6:0]  seg1, seg4;
  logic [3:0]  dig1, dig4;

  always #5 clk = ~clk;

  display_scan_ctrl #(.SCAN_DIV(1)) u_dut (
    .CLK_i       (clk),
    .RST_i       (rst),
    .IN_i        (in_val),
    .IN_VALID_i  (in_valid),
    .IN_READY_o  (rdy1),
    .CONV_DONE_o (done1),
    .SEG_o       (seg1),
    .DIG_o       (dig1)
  );

  display_scan_ctrl #(.SCAN_DIV(4)) u_dut4 (
    .CLK_i       (clk),
    .RST_i       (rst),
    .IN_i        (in_val),
    .IN_VALID_i  (in_valid),
    .IN_READY_o  (rdy4),
    .CONV_DONE_o (done4),
    .SEG_o       (seg4),
    .DIG_o       (dig4)
  );

`ifdef BLANK_LZ_EN
  localparam logic [6:0] ZB = 7'b0000000;
`else
  localparam logic [6:0] ZB = 7'b1111110;
`endif

  typedef struct packed {
    logic [11:0]     val;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t tbl [5];

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: cycles since reset, pending value, busy countdown.
  int m_n    = 0;
  int m_cnt  = 0;
  int m_pend = 0;
  int m_disp = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_n    <= 0;
      m_cnt  <= 0;
      m_disp <= 0;
    end else begin
      m_n <= m_n + 1;
      if (m_cnt == 0) begin
        if (in_valid) begin
          m_cnt  <= 13;
          m_pend <= int'(in_val);
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_disp <= m_pend;
      end
    end
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
`ifdef BLANK_LZ_EN
    if (i > 0 && v < p) return 7'b0000000;
`endif
    return pat((v / p) % 10);
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag);
    int i1, i4;
    i1 = m_n % 4;
    i4 = (m_n / 4) % 4;
    check({tag, ".rdy1"}, 32'(rdy1), 32'(m_cnt == 0));
    check({tag, ".done1"}, 32'(done1), 32'(m_cnt == 1));
    check({tag, ".dig1"}, 32'(dig1), 32'(onehot(i1)));
    check({tag, ".seg1"}, 32'(seg1), 32'(exp_seg(m_disp, i1)));
    check({tag, ".rdy4"}, 32'(rdy4), 32'(m_cnt == 0));
    check({tag, ".done4"}, 32'(done4), 32'(m_cnt == 1));
    check({tag, ".dig4"}, 32'(dig4), 32'(onehot(i4)));
    check({tag, ".seg4"}, 32'(seg4), 32'(exp_seg(m_disp, i4)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic scan4(input string tag, input int t);
    int i;
    for (int c = 0; c < 4; c++) begin
      i = m_n % 4;
      check($sformatf("%s.dig%0d", tag, c), 32'(dig1), 32'(onehot(i)));
      check($sformatf("%s.seg%0d", tag, i), 32'(seg1), 32'(tbl[t].seg[i]));
      @(negedge clk);
    end
  endtask

  initial begin
    int nlow, ndone, k;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_val   = '0;

    // Segment order in each entry: digit 3, 2, 1, 0.
    tbl[0] = {12'd1234, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};
    tbl[1] = {12'd4095, 7'b0110011, 7'b1111110, 7'b1111011, 7'b1011011};
    tbl[2] = {12'd7,    ZB,         ZB,         ZB,         7'b1110000};
    tbl[3] = {12'd0,    ZB,         ZB,         ZB,         7'b1111110};
    tbl[4] = {12'd100,  ZB,         7'b0110000, 7'b1111110, 7'b1111110};

    @(negedge clk);
    do_reset();
    check("rst.rdy", 32'(rdy1), 32'd1);
    check("rst.done", 32'(done1), 32'd0);
    check("rst.dig", 32'(dig1), 32'b0001);
    check("rst.seg", 32'(seg1), 32'b1111110);

    for (int t = 0; t < 5; t++) begin
      do_reset();
      in_val   = tbl[t].val;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      nlow  = 0;
      ndone = 0;
      for (int c = 0; c < 13; c++) begin
        if (!rdy1) nlow++;
        if (done1) ndone++;
        @(negedge clk);
      end
      check($sformatf("v%0d.busy", t), 32'(nlow), 32'd13);
      check($sformatf("v%0d.done", t), 32'(ndone), 32'd1);
      check($sformatf("v%0d.rdy", t), 32'(rdy1), 32'd1);
      scan4($sformatf("v%0d", t), t);
    end

    // Second value offered mid-conversion is dropped.
    do_reset();
    in_val   = 12'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    in_val   = 12'd999;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    ndone = 0;
    k = 0;
    while (!rdy1 && k < 20) begin
      if (done1) ndone++;
      @(negedge clk);
      k++;
    end
    check("busy.rdy", 32'(rdy1), 32'd1);
    check("busy.done", 32'(ndone), 32'd1);
    scan4("busy", 4);
    check("busy.noqueue", 32'(rdy1), 32'd1);

    // Reset in the middle of a conversion.
    do_reset();
    in_val   = 12'd555;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.rdy", 32'(rdy1), 32'd1);
    check("abort.done", 32'(done1), 32'd0);
    check("abort.dig", 32'(dig1), 32'b0001);
    check("abort.seg", 32'(seg1), 32'b1111110);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      if (done1) ndone++;
      check($sformatf("abort.seg%0d", c), 32'(seg1),
            32'(tbl[3].seg[m_n % 4]));
      @(negedge clk);
    end
    check("abort.nodone", 32'(ndone), 32'd0);

    // Divided scan: one digit per 4 cycles.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      check($sformatf("div4.dig%0d", c), 32'(dig4),
            32'(onehot((c / 4) % 4)));
      @(negedge clk);
    end

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      check_all($sformatf("rnd%0d", c));
      in_valid = ($urandom_range(0, 2) == 0);
      in_val   = ($urandom_range(0, 7) == 0) ? 12'd4095
                                              : 12'($urandom_range(0, 4095));
      rst      = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
